// File: rtl/cpu_controller_pkg.sv
// Shared ISA constants, FSM state encoding and instruction classes for the
// simple RISC machine controller.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_MVN    = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        C_MOV_IMM,
        C_MOV_REG,
        C_ADD,
        C_CMP,
        C_AND,
        C_MVN,
        C_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, builds the
// sign-extended immediates and classifies the instruction.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output iclass_t     iclass
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    always_comb begin
        iclass = C_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      iclass = C_MOV_IMM;
            else if (op == OP_MOV_REG) iclass = C_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                ALU_ADD: iclass = C_ADD;
                ALU_CMP: iclass = C_CMP;
                ALU_AND: iclass = C_AND;
                default: iclass = C_MVN;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, control FSM and Moore output decode driving the
// datapath control word; one instruction per s pulse, w high when idle.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [15:0] datapath_in,
    output logic        vsel,
    output logic        write,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [15:0] aselin,
    output logic [15:0] bselin,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    iclass_t     iclass;

    instr_dec u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (datapath_in),
        .sximm5 (bselin),
        .iclass (iclass)
    );

    assign aselin = '0;

    // IR only captures in WAIT, so DECODE sees the word loaded on the s edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && load) ir <= in;
        end
    end

    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT:      next_state = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (iclass)
                    C_MOV_IMM:                next_state = S_WRITE_IMM;
                    C_MOV_REG, C_MVN:         next_state = S_GET_B;
                    C_ADD, C_CMP, C_AND:      next_state = S_GET_A;
                    default:                  next_state = S_WAIT;
                endcase
            end
            S_WRITE_IMM: next_state = S_WAIT;
            S_GET_A:     next_state = S_GET_B;
            S_GET_B:     next_state = S_ALU;
            S_ALU:       next_state = (iclass == C_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: next_state = S_WAIT;
            default:     next_state = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        vsel     = 1'b0;
        write    = 1'b0;
        writenum = '0;
        readnum  = '0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = '0;
        ALUop    = '0;
        case (state)
            S_WAIT:      w = 1'b1;
            S_WRITE_IMM: begin
                vsel     = 1'b1;
                write    = 1'b1;
                writenum = rn;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                shift = sh;
                asel  = (iclass == C_MOV_REG) || (iclass == C_MVN);
                ALUop = (iclass == C_MOV_REG) ? ALU_ADD : op;
                loads = (iclass == C_CMP);
                loadc = (iclass != C_CMP);
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                writenum = rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a behavioural
// per-instruction control-word sequence model.
module tb_cpu_controller;

    typedef struct packed {
        logic       w;
        logic       vsel;
        logic       write;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } cw_t;

    localparam int PH_DEC  = 0;
    localparam int PH_WIMM = 1;
    localparam int PH_RDA  = 2;
    localparam int PH_RDB  = 3;
    localparam int PH_EXE  = 4;
    localparam int PH_WREG = 5;
    localparam int PH_IDLE = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w, vsel, write, loada, loadb, loadc, loads, asel, bsel;
    logic [15:0] datapath_in, aselin, bselin;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    int tests_run = 0;
    int tests_failed = 0;

    cpu_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .load        (load),
        .s           (s),
        .w           (w),
        .datapath_in (datapath_in),
        .vsel        (vsel),
        .write       (write),
        .writenum    (writenum),
        .readnum     (readnum),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .aselin      (aselin),
        .bselin      (bselin),
        .shift       (shift),
        .ALUop       (ALUop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic cw_t observed();
        cw_t c;
        c = '{w: w, vsel: vsel, write: write, writenum: writenum, readnum: readnum,
              loada: loada, loadb: loadb, loadc: loadc, loads: loads,
              asel: asel, bsel: bsel, shift: shift, aluop: ALUop};
        return c;
    endfunction

    // Edge counts from the timing table, independent of the phase list below.
    function automatic int n_steps(input logic [15:0] ir);
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return 3;
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return 5;
        if (ir[15:13] == 3'b101) return (ir[12:11] == 2'b01 || ir[12:11] == 2'b11) ? 5 : 6;
        return 2;
    endfunction

    function automatic cw_t exp_word(input logic [15:0] ir, input int k);
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        bit is_imm  = (opc == 3'b110) && (op == 2'b10);
        bit is_movr = (opc == 3'b110) && (op == 2'b00);
        bit is_alu  = (opc == 3'b101);
        bit is_cmp  = is_alu && (op == 2'b01);
        bit is_mvn  = is_alu && (op == 2'b11);
        int seq[$];
        int ph;
        cw_t c = '0;
        seq.push_back(PH_DEC);
        if (is_imm) seq.push_back(PH_WIMM);
        else if (is_movr || is_alu) begin
            if (is_alu && !is_mvn) seq.push_back(PH_RDA);
            seq.push_back(PH_RDB);
            seq.push_back(PH_EXE);
            if (!is_cmp) seq.push_back(PH_WREG);
        end
        seq.push_back(PH_IDLE);
        ph = (k - 1 < seq.size()) ? seq[k - 1] : PH_IDLE;
        case (ph)
            PH_IDLE: c.w = 1'b1;
            PH_WIMM: begin c.vsel = 1'b1; c.write = 1'b1; c.writenum = ir[10:8]; end
            PH_RDA:  begin c.readnum = ir[10:8]; c.loada = 1'b1; end
            PH_RDB:  begin c.readnum = ir[2:0]; c.loadb = 1'b1; end
            PH_EXE: begin
                c.shift = ir[4:3];
                c.asel  = is_movr || is_mvn;
                c.aluop = is_alu ? op : 2'b00;
                c.loads = is_cmp;
                c.loadc = !is_cmp;
            end
            PH_WREG: begin c.write = 1'b1; c.writenum = ir[7:5]; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        int val = int'(v) & ((1 << bits) - 1);
        if (val >= (1 << (bits - 1))) val = val - (1 << bits);
        return 16'(val);
    endfunction

    task automatic run(input logic [15:0] instr, input bit same_edge, input bit b2b);
        int n = n_steps(instr);
        int total = b2b ? 2 * n : n;
        int kk;
        @(negedge clk);
        in = instr;
        load = 1'b1;
        s = same_edge;
        if (!same_edge) begin
            @(posedge clk); #1;
            check_val("load_only_wait", 32'(observed()), 32'(exp_word(instr, n)));
            @(negedge clk);
            load = 1'b0;
            s = 1'b1;
            in = 16'($urandom);
        end
        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            kk = (k > n) ? k - n : k;
            check_val($sformatf("cw_%h_k%0d", instr, k), 32'(observed()), 32'(exp_word(instr, kk)));
            if (k == 1 || k == total) begin
                check_val("datapath_in", 32'(datapath_in), 32'(sext(instr, 8)));
                check_val("bselin", 32'(bselin), 32'(sext(instr, 5)));
                check_val("aselin", 32'(aselin), 32'h0);
            end
            if (k < total) begin
                @(negedge clk);
                in = 16'($urandom);
                if (kk == n) begin
                    load = 1'b0;
                    s = 1'b1;
                end else begin
                    load = 1'($urandom);
                    s = 1'($urandom);
                end
            end
        end
        @(negedge clk);
        load = 1'b0;
        s = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        cw_t idle_w;
        idle_w = exp_word(16'h0000, 2);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_cw", 32'(observed()), 32'(idle_w));
        check_val("reset_dp_in", 32'(datapath_in), 32'h0);
        check_val("reset_bselin", 32'(bselin), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        run(16'hD007, 1'b0, 1'b0);
        run(16'hD3FF, 1'b1, 1'b0);
        run(16'hA140, 1'b0, 1'b0);
        run(16'hA908, 1'b1, 1'b0);
        run(16'hC085, 1'b1, 1'b0);
        run(16'hB8E3, 1'b1, 1'b1);
        run(16'hE123, 1'b1, 1'b0);
        run(16'hA140, 1'b1, 1'b1);

        // Reset asserted while an ADD sits in GET_A.
        @(negedge clk);
        in = 16'hA140; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        check_val("rst_mid_geta", 32'(observed()), 32'(exp_word(16'hA140, 2)));
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_val("rst_mid_cw", 32'(observed()), 32'(idle_w));
        check_val("rst_mid_dp_in", 32'(datapath_in), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("rst_mid_quiet", 32'(observed()), 32'(idle_w));
        end

        for (int i = 0; i < 60; i++)
            run(rand_instr(), 1'($urandom), ($urandom_range(0, 3) == 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and control FSM for the simple RISC machine. It sits directly upstream of `datapath` and drives its full control word: register-file addresses, load strobes, operand selects, shift, ALUop and the immediate on `datapath_in`. It executes one 16-bit instruction per `s` pulse and raises `w` when idle.

## Interface
- No parameters. Widths are fixed by the ISA.
- `clk` in 1: rising-edge clock shared with `datapath`.
- `reset_n` in 1: reset is synchronous and active-low.
- `in` in 16: instruction word.
- `load` in 1: load `in` into the IR.
- `s` in 1: start executing the IR.
- `w` out 1: high when in WAIT.
- `datapath_in` out 16: sximm8 = sign-extended IR[7:0].
- `vsel` out 1: 1 selects `datapath_in`, 0 selects C for register writeback.
- `write` out 1: register-file write strobe.
- `writenum`, `readnum` out 3: register-file addresses.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath register strobes.
- `asel`, `bsel` out 1 each: 1 selects `aselin` or `bselin`.
- `aselin` out 16: constant 16'h0000.
- `bselin` out 16: sximm5 = sign-extended IR[4:0].
- `shift` out 2, `ALUop` out 2: datapath function select.

## Operation
- IR fields:
  - opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], im8 = [7:0].
- Supported instructions:
  - 110/10: MOV Rn,#im8.
  - 110/00: MOV Rd,Rm{sh}.
  - 101/00: ADD Rd,Rn,Rm{sh}.
  - 101/01: CMP Rn,Rm{sh}.
  - 101/10: AND Rd,Rn,Rm{sh}.
  - 101/11: MVN Rd,Rm{sh}.
- Any other opcode/op pair is illegal.
- IR loading:
  - The IR loads on an edge with `load`=1 only while in WAIT.
  - `load` is ignored in every other state.
- FSM states and transitions:
  - WAIT: `s`=1 → DECODE.
  - DECODE: MOV imm → WRITE_IMM. MOV reg or MVN → GET_B. ADD, CMP or AND → GET_A. Illegal → WAIT.
  - WRITE_IMM → WAIT.
  - GET_A → GET_B.
  - GET_B → ALU.
  - ALU: CMP → WAIT, otherwise → WRITE_REG.
  - WRITE_REG → WAIT.
- Outputs are Moore-style, decoded from state and IR. Every strobe is 0 unless listed.
  - WAIT: `w`=1.
  - WRITE_IMM: `vsel`=1, `write`=1, `writenum`=Rn.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `shift`=sh and `bsel`=0.
    - `asel`=1 for MOV reg and MVN, else 0.
    - `ALUop`=op for opcode 101; `ALUop`=00 for MOV reg.
    - CMP: `loads`=1, `loadc`=0. All others: `loadc`=1.
  - WRITE_REG: `vsel`=0, `write`=1, `writenum`=Rd.
- `datapath_in`, `bselin` and `aselin` are continuous functions of the IR.

## Timing
- Reset (edge with `reset_n`=0):
  - State becomes WAIT and IR becomes 0.
  - `w`=1; all strobes, `asel`, `bsel` and `vsel` are 0.
  - `shift`, `ALUop`, `readnum` and `writenum` are 0.
  - `datapath_in` and `bselin` are 0.
- Reset mid-instruction: the next edge returns to WAIT and no further strobes are issued.
- Edges from the edge sampling `s` until back in WAIT:
  - MOV imm: 3.
  - MOV reg, MVN, CMP: 5.
  - ADD, AND: 6.
  - Illegal: 2.
- `load` and `s` on the same WAIT edge: the IR captures `in`, and DECODE uses the new IR.
- `s` outside WAIT is ignored. `s` held high in WAIT starts the next instruction back-to-back.
- Each strobe is high for exactly one cycle per instruction.

## Structure
- `cpu_pkg` holds:
  - opcode/op constants;
  - state encoding, as an enum of 7 states;
  - ALUop constants (ADD=00, CMP=01, AND=10, MVN=11).
- Sub-module `instr_dec` is combinational: IR → fields, sximm8, sximm5 and instruction class.
- `cpu_controller` owns the IR register, the state register and the output decode.

## Test plan
- Reset, then MOV R0,#7 (16'hD007), with `load` then `s`:
  - WRITE_IMM shows `write`=1, `vsel`=1, `writenum`=0, `datapath_in`=16'h0007.
  - `w` returns to 1 on the 3rd edge.
- MOV R3,#-1 (16'hD3FF) → `datapath_in`=16'hFFFF, `writenum`=3.
- ADD R2,R1,R0 (16'hA140) produces this strobe sequence, with `w` back to 1 after 6 edges:
  - `readnum`=1 with `loada`;
  - `readnum`=0 with `loadb`;
  - `ALUop`=00, `asel`=0, `shift`=00 with `loadc`;
  - `writenum`=2 with `write` and `vsel`=0.
- CMP R1,R0,LSL (16'hA908):
  - ALU state shows `loads`=1, `loadc`=0, `shift`=01, `ALUop`=01.
  - No `write` is issued; back to WAIT after 5 edges.
- MOV R4,R5 (16'hC085, writenum=Rd=4, readnum=Rm=5):
  - `loadb` is issued with `readnum`=5; `asel`=1 and `ALUop`=00 in ALU; `write` with `writenum`=4.
  - With `load`=1 and `in`=16'hD0FF applied during GET_B, the IR is unchanged.
- Drive `reset_n`=0 during GET_A of an ADD:
  - The next edge shows WAIT, `w`=1 and all strobes 0.
  - No `write` follows.
